// File: rtl/door_timer_ctrl.sv
// Door interval timer: clears the external seconds counter, then times a latched
// interval. Optional clear-handshake watchdog enabled by DOOR_TIMER_WATCHDOG_EN.
module door_timer_ctrl #(
  parameter int unsigned ACK_WAIT = 8
) (
  input  logic       clk,
  input  logic       reseta,
  input  logic       start,
  input  logic [3:0] duration,
  input  logic       abort,
  input  logic [3:0] timeout,
  input  logic       DoneResetClock,
  output logic       clk_reset,
  output logic       busy,
  output logic       expired,
  output logic [3:0] elapsed,
  output logic       fault
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WD_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3
`ifdef DOOR_TIMER_WATCHDOG_EN
    , S_FAULT = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] elapsed_d;
  logic             clk_reset_d, busy_d, expired_d;

`ifdef DOOR_TIMER_WATCHDOG_EN
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             fault_d;
`else
  logic             unused_ack_wait;
  assign unused_ack_wait = |WD_W'(ACK_WAIT);
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) begin
      state_q   <= S_IDLE;
      dur_q     <= '0;
      clk_reset <= 1'b0;
      busy      <= 1'b0;
      expired   <= 1'b0;
      elapsed   <= '0;
`ifdef DOOR_TIMER_WATCHDOG_EN
      wd_cnt_q  <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      clk_reset <= clk_reset_d;
      busy      <= busy_d;
      expired   <= expired_d;
      elapsed   <= elapsed_d;
`ifdef DOOR_TIMER_WATCHDOG_EN
      wd_cnt_q  <= wd_cnt_d;
      fault     <= fault_d;
`endif
    end
  end

  // Next state; outputs derive from the state being entered so they land with it
  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    elapsed_d = elapsed;
    expired_d = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_CLR;
            dur_d     = duration;
            elapsed_d = '0;
          end
        end
        S_CLR: begin
          elapsed_d = '0;
          if (DoneResetClock) begin
            state_d = S_RUN;
          end
`ifdef DOOR_TIMER_WATCHDOG_EN
          else if (wd_cnt_q == WD_W'(ACK_WAIT - 1)) begin
            state_d = S_FAULT;
          end
`endif
        end
        S_RUN: begin
          elapsed_d = timeout;
          if (timeout >= dur_q) begin
            state_d   = S_DONE;
            expired_d = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
`ifdef DOOR_TIMER_WATCHDOG_EN
        S_FAULT: begin
          state_d = S_FAULT;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    clk_reset_d = (state_d == S_CLR);
    busy_d      = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_DONE);
  end

`ifdef DOOR_TIMER_WATCHDOG_EN
  // Cycles spent in CLR without acknowledgement; restarts on any CLR exit
  always_comb begin
    wd_cnt_d = '0;
    fault_d  = (state_d == S_FAULT);
    if ((state_q == S_CLR) && (state_d == S_CLR)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_door_timer_ctrl.sv
// Directed bench for door_timer_ctrl: nominal interval, zero duration, abort,
// ignored inputs, asynchronous reset and (when enabled) the handshake watchdog.
module tb_door_timer_ctrl;

  logic       clk;
  logic       reseta;
  logic       start;
  logic [3:0] duration;
  logic       abort;
  logic [3:0] timeout;
  logic       DoneResetClock;
  logic       clk_reset;
  logic       busy;
  logic       expired;
  logic [3:0] elapsed;
  logic       fault;

  int checks = 0;
  int errors = 0;

  door_timer_ctrl #(.ACK_WAIT(8)) dut (
    .clk           (clk),
    .reseta        (reseta),
    .start         (start),
    .duration      (duration),
    .abort         (abort),
    .timeout       (timeout),
    .DoneResetClock(DoneResetClock),
    .clk_reset     (clk_reset),
    .busy          (busy),
    .expired       (expired),
    .elapsed       (elapsed),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic outs(input string tag, input logic cr, input logic b, input logic ex,
                      input logic [3:0] el, input logic f);
    chk({tag, ".clk_reset"}, 8'(clk_reset), 8'(cr));
    chk({tag, ".busy"},      8'(busy),      8'(b));
    chk({tag, ".expired"},   8'(expired),   8'(ex));
    chk({tag, ".elapsed"},   8'(elapsed),   8'(el));
    chk({tag, ".fault"},     8'(fault),     8'(f));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reseta = 1'b0;
    start = 1'b0;
    duration = 4'd0;
    abort = 1'b0;
    timeout = 4'd0;
    DoneResetClock = 1'b0;
    #12;
    outs("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1 reseta = 1'b1;
    tick;
    outs("idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Nominal: duration 3, ack after two CLR cycles, timeout 0..3
    start = 1'b1; duration = 4'd3;
    tick; outs("nom_clr1", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    start = 1'b0;
    tick; outs("nom_clr2", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    DoneResetClock = 1'b1;
    tick; outs("nom_run", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    DoneResetClock = 1'b0; timeout = 4'd0;
    tick; outs("nom_t0", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    timeout = 4'd1;
    tick; outs("nom_t1", 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
    timeout = 4'd2;
    tick; outs("nom_t2", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    timeout = 4'd3;
    tick; outs("nom_done", 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
    tick; outs("nom_idle", 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);

    // Zero duration: expiry on first RUN cycle
    timeout = 4'd0;
    start = 1'b1; duration = 4'd0;
    tick; outs("zero_clr", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    start = 1'b0; DoneResetClock = 1'b1;
    tick; outs("zero_run", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    DoneResetClock = 1'b0;
    tick; outs("zero_done", 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    tick; outs("zero_idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Abort in RUN with timeout 2, then start+abort together in IDLE
    start = 1'b1; duration = 4'd5;
    tick;
    start = 1'b0; DoneResetClock = 1'b1;
    tick;
    DoneResetClock = 1'b0; timeout = 4'd2;
    tick; outs("abt_run", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    abort = 1'b1;
    tick; outs("abt_idle", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    start = 1'b1;
    tick; outs("abt_start", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    tick; outs("abt_start2", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    abort = 1'b0; start = 1'b0;

    // Ignored inputs: start(dur 9) and ack during RUN with dur_q=5
    timeout = 4'd0;
    start = 1'b1; duration = 4'd5;
    tick; outs("ign_clr", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    start = 1'b0; DoneResetClock = 1'b1;
    tick;
    DoneResetClock = 1'b1; start = 1'b1; duration = 4'd9; timeout = 4'd1;
    tick; outs("ign_t1", 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
    start = 1'b0; DoneResetClock = 1'b0; timeout = 4'd4;
    tick; outs("ign_t4", 1'b0, 1'b1, 1'b0, 4'd4, 1'b0);
    timeout = 4'd5;
    tick; outs("ign_t5", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    tick; outs("ign_idle", 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);

    // Asynchronous reset mid-CLR, then a normal interval after release
    timeout = 4'd0;
    start = 1'b1; duration = 4'd2;
    tick; outs("ar_clr", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    start = 1'b0;
    #3 reseta = 1'b0;
    #1 outs("ar_async", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1 reseta = 1'b1;
    start = 1'b1; duration = 4'd2;
    tick; outs("ar_clr2", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    start = 1'b0; DoneResetClock = 1'b1;
    tick;
    DoneResetClock = 1'b0; timeout = 4'd2;
    tick; outs("ar_done", 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
    tick; outs("ar_idle", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);

`ifdef DOOR_TIMER_WATCHDOG_EN
    // Watchdog: no ack -> FAULT after 8 CLR cycles, abort clears it
    timeout = 4'd0;
    start = 1'b1; duration = 4'd4;
    tick; outs("wd_clr1", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    outs("wd_clr8", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick; outs("wd_fault", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick; outs("wd_hold", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    abort = 1'b1;
    tick; outs("wd_abort", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    abort = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_timer_ctrl.md
DOOR_TIMER_CTRL -- requirements
Module: door_timer_ctrl

Interface
REQ-001 Parameter ACK_WAIT, default 8: max clk cycles in CLR awaiting DoneResetClock (watchdog builds only).
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 reseta  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to time an interval; sampled only in IDLE.
REQ-005 duration  input  4  interval length in seconds; latched when start is accepted.
REQ-006 abort  input  1  cancel any activity; highest priority after reset.
REQ-007 timeout  input  4  seconds count from the seconds-counter block.
REQ-008 DoneResetClock  input  1  seconds-counter acknowledgement that its count is cleared.
REQ-009 clk_reset  output  1  registered, active-high clear request to the seconds-counter block.
REQ-010 busy  output  1  high in CLR, RUN and DONE.
REQ-011 expired  output  1  one-cycle pulse when the interval completes.
REQ-012 elapsed  output  4  seconds elapsed in the current interval.
REQ-013 fault  output  1  handshake failure flag (watchdog builds only).

Function
REQ-014 FSM states IDLE, CLR, RUN, DONE, FAULT; all outputs registered.
REQ-015 IDLE: start=1 and abort=0 -> latch duration into dur_q, go CLR; otherwise stay.
REQ-016 CLR: clk_reset=1 and elapsed cleared to 0; DoneResetClock=1 sampled -> go RUN, clk_reset=0 from the same edge.
REQ-017 DoneResetClock is ignored in every state other than CLR.
REQ-018 RUN: elapsed <= timeout each cycle; timeout >= dur_q -> go DONE, expired=1 for exactly that one cycle.
REQ-019 dur_q=0 -> expiry on the first RUN cycle.
REQ-020 DONE: elapsed holds the final value; the next cycle returns to IDLE; busy=0 from IDLE entry.
REQ-021 start while busy is ignored; dur_q is not updated.
REQ-022 abort=1 in any state -> IDLE next cycle; clk_reset=0, expired=0, fault=0; elapsed holds its value.
REQ-023 start and abort in the same IDLE cycle -> stay IDLE.
REQ-024 Interval never exceeds 15 s, so the 4-bit timeout wrap is unreachable within RUN; no wrap handling is required.
REQ-025 Minimum latency from start to RUN is 3 edges: the CLR entry edge, the counter's sample of the clear request, and the acknowledge sample.

Reset
REQ-026 reseta=0 immediately forces IDLE, clk_reset=0, busy=0, expired=0, elapsed=0, fault=0, dur_q=0, and clears the watchdog counter.
REQ-027 Reset mid-interval discards the interval; no expired pulse is produced.
REQ-028 Reset release is used directly, with no synchronizer inside the block.

Configuration
REQ-029 Macro DOOR_TIMER_WATCHDOG_EN defined: an 8-bit counter counts cycles in CLR; reaching ACK_WAIT without DoneResetClock -> FAULT.
REQ-030 In FAULT: fault=1, clk_reset=0 and busy=0; exit is by abort or reset only.
REQ-031 Macro undefined: CLR waits indefinitely, fault is tied to 0, FAULT state and counter are absent, and ACK_WAIT is unused.

Verification
REQ-032 Nominal: start with duration=3 in IDLE, ack 2 cycles later, timeout steps 0..3 -> clk_reset high for 2 cycles, one expired pulse when timeout=3, elapsed=3, back to IDLE.
REQ-033 Zero duration: start with duration=0, ack returned -> expired on the first RUN cycle, elapsed=0.
REQ-034 Abort: abort while in RUN with timeout=2 -> IDLE next cycle, no expired pulse, elapsed=2; abort and start together in IDLE -> remains IDLE.
REQ-035 Ignored inputs: start with duration=9 during RUN with dur_q=5 -> expiry still at timeout=5; DoneResetClock pulsed in RUN -> no effect.
REQ-036 Watchdog (macro on, ACK_WAIT=8): start with no ack -> FAULT after 8 CLR cycles, fault=1, clk_reset=0; then abort -> fault=0, state IDLE.
REQ-037 Async reset: reseta low mid-CLR between clock edges -> all outputs 0 immediately; start accepted normally after release.
